// File: rtl/ripple_add_pkg.sv
// Shared types and constants for the multi-precision ripple add/subtract sequencer.
package ripple_add_pkg;

  localparam int WORD_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Two's-complement overflow from operand and result sign bits (b already inverted for subtract).
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/ripple_carry_adder8.sv
// 8-bit combinational ripple-carry adder built from a chain of full adders.
module ripple_carry_adder8
  import ripple_add_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic              cout,
  output logic [WORD_W-1:0] sum
);

  logic [WORD_W:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < WORD_W; gi++) begin : g_fa
      assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = carry[WORD_W];

endmodule

// File: rtl/ripple_add_sequencer.sv
// Multi-precision add/subtract: streams NWORDS bytes LSB-first through one 8-bit
// ripple adder, carrying between words in carry_q, and returns sum plus flags.
module ripple_add_sequencer
  import ripple_add_pkg::*;
#(
  parameter int NWORDS = 4,
  localparam int W     = WORD_W * NWORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic         req_cin,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic         rsp_ovf
);

  localparam int                IDX_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NWORDS - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                carry_q, carry_d;
  logic [W-1:0]        a_q, a_d;
  logic [W-1:0]        b_q, b_d;
  logic [W-1:0]        sum_q, sum_d;

  logic [WORD_W-1:0]   add_a, add_b, add_sum;
  logic                add_cout;
  logic                accept;

  assign accept = req_valid && (state_q == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)              state_d = RUN;
      RUN:     if (idx_q == LAST_IDX)   state_d = DONE;
      DONE:    if (rsp_ready)           state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == DONE);
  end

  // Word mux: the adder only ever sees registered operands and carry.
  assign add_a = a_q[idx_q * WORD_W +: WORD_W];
  assign add_b = b_q[idx_q * WORD_W +: WORD_W];

  ripple_carry_adder8 u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .cout (add_cout),
    .sum  (add_sum)
  );

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = req_a;
          b_d     = (req_op == OP_SUB) ? ~req_b : req_b;
          carry_d = (req_op == OP_SUB) ? ~req_cin : req_cin;
          idx_d   = '0;
        end
      end
      RUN: begin
        sum_d[idx_q * WORD_W +: WORD_W] = add_sum;
        carry_d = add_cout;
        if (idx_q != LAST_IDX) begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  // Response fields come straight from state that only moves in RUN or on accept,
  // so they stay put through DONE back-pressure and linger in IDLE.
  assign rsp_sum  = sum_q;
  assign rsp_cout = carry_q;
  assign rsp_ovf  = signed_ovf(a_q[W-1], b_q[W-1], sum_q[W-1]);

endmodule

// File: tb/tb_ripple_add_sequencer.sv
// Self-checking bench: directed, back-pressure, reset-abort, random and back-to-back
// scenarios on a 4-word instance plus a small 1-word instance.
module tb_ripple_add_sequencer;

  localparam int NW = 4;
  localparam int W  = 8 * NW;
  localparam longint SMAX = (longint'(1) <<< (W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (W - 1));

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_op, req_cin, rsp_ready;
  logic [W-1:0] req_a, req_b;
  logic         req_ready, rsp_valid, rsp_cout, rsp_ovf;
  logic [W-1:0] rsp_sum;

  logic         req_valid1, req_op1, req_cin1, rsp_ready1;
  logic [7:0]   req_a1, req_b1;
  logic         req_ready1, rsp_valid1, rsp_cout1, rsp_ovf1;
  logic [7:0]   rsp_sum1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ripple_add_sequencer #(.NWORDS(NW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
  );

  ripple_add_sequencer #(.NWORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_op(req_op1),
    .req_a(req_a1), .req_b(req_b1), .req_cin(req_cin1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_sum(rsp_sum1), .rsp_cout(rsp_cout1), .rsp_ovf(rsp_ovf1)
  );

  // Reference: exact integer arithmetic; subtract means a - b - borrow_in.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic op, input logic cin);
    res_t         r;
    longint       exact;
    logic [W:0]   wide;
    if (op == 1'b0) begin
      wide   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      r.sum  = wide[W-1:0];
      r.cout = wide[W];
      exact  = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    end else begin
      r.sum  = a - b - {{(W-1){1'b0}}, cin};
      r.cout = ({1'b0, a} >= ({1'b0, b} + {{W{1'b0}}, cin}));
      exact  = longint'($signed(a)) - longint'($signed(b)) - longint'(cin);
    end
    r.ovf = (exact > SMAX) || (exact < SMIN);
    return r;
  endfunction

  // Runs one request/response; lat is the edge (counted from accept) at which
  // the consumer first samples rsp_valid high, 0 on timeout. Entered #1 after an edge.
  task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                        input logic cin, input int ready_delay,
                        output res_t got, output int lat);
    int k;
    req_a = a; req_b = b; req_op = op; req_cin = cin; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 50; i++) begin
      if (rsp_valid) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    got = '{sum: rsp_sum, cout: rsp_cout, ovf: rsp_ovf};
    repeat (ready_delay) begin
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    $display("txn op=%0d a=%h b=%h cin=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
             op, a, b, cin, got.sum, got.cout, got.ovf, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b sum=%h cout=%b ovf=%b, required rdy=1 vld=0 sum=0 cout=0 ovf=0",
               req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf);
    end
    checks++;
    if ({req_ready1, rsp_valid1, rsp_sum1, rsp_cout1, rsp_ovf1} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state_nw1: rdy=%b vld=%b sum=%h, required rdy=1 vld=0 sum=00",
               req_ready1, rsp_valid1, rsp_sum1);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [4] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0005};
    logic [W-1:0] tb [4] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 32'h0000_0007};
    logic         top [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic         tcin[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    res_t         texp[4] = '{'{32'h0000_0100, 1'b0, 1'b0}, '{32'h0000_0000, 1'b1, 1'b0},
                              '{32'h7FFF_FFFF, 1'b1, 1'b1}, '{32'hFFFF_FFFE, 1'b0, 1'b0}};
    res_t got;
    int   lat;
    for (int i = 0; i < 4; i++) begin
      do_txn(ta[i], tb[i], top[i], tcin[i], 0, got, lat);
      checks++;
      if (got !== texp[i]) begin
        errors++;
        $display("FAIL directed_%0d: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                 i, got.sum, got.cout, got.ovf, texp[i].sum, texp[i].cout, texp[i].ovf);
      end
      checks++;
      if (lat !== NW + 1) begin
        errors++;
        $display("FAIL directed_latency_%0d: got %0d, required %0d", i, lat, NW + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a1, b1, a2, b2;
    res_t held, exp1, exp2, got2;
    int   lat;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    exp1 = model(a1, b1, 1'b0, 1'b1);
    exp2 = model(a2, b2, 1'b1, 1'b0);
    req_a = a1; req_b = b1; req_op = 1'b0; req_cin = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_a = a2; req_b = b2; req_op = 1'b1; req_cin = 1'b0;
    for (int i = 0; i < 50 && !rsp_valid; i++) begin
      @(posedge clk); #1;
    end
    held = '{sum: rsp_sum, cout: rsp_cout, ovf: rsp_ovf};
    checks++;
    if (held !== exp1 || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_first_result: vld=%b sum=%h cout=%b ovf=%b, required vld=1 sum=%h cout=%b ovf=%b",
               rsp_valid, held.sum, held.cout, held.ovf, exp1.sum, exp1.cout, exp1.ovf);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid, req_ready, rsp_sum, rsp_cout, rsp_ovf} !== {1'b1, 1'b0, held}) begin
        errors++;
        $display("FAIL bp_hold_%0d: vld=%b rdy=%b sum=%h, required vld=1 rdy=0 sum=%h",
                 i, rsp_valid, req_ready, rsp_sum, held.sum);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL bp_release_idle: rdy=%b vld=%b, required rdy=1 vld=0", req_ready, rsp_valid);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_second_accept: rdy=%b, required 0 one cycle after idle", req_ready);
    end
    lat = 0;
    for (int i = 1; i <= 50; i++) begin
      if (rsp_valid) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    got2 = '{sum: rsp_sum, cout: rsp_cout, ovf: rsp_ovf};
    checks++;
    if (got2 !== exp2 || lat !== NW + 1) begin
      errors++;
      $display("FAIL bp_second_result: sum=%h cout=%b ovf=%b lat=%0d, required sum=%h cout=%b ovf=%b lat=%0d",
               got2.sum, got2.cout, got2.ovf, lat, exp2.sum, exp2.cout, exp2.ovf, NW + 1);
    end
    $display("txn backpressure second op=1 a=%h b=%h -> sum=%h", a2, b2, got2.sum);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    res_t got;
    int   lat;
    req_a = 32'hDEAD_BEEF; req_b = 32'h0123_4567; req_op = 1'b0; req_cin = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: rdy=%b vld=%b sum=%h cout=%b ovf=%b, required rdy=1 vld=0 sum=0 cout=0 ovf=0",
               req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_abort_%0d: vld=%b, required 0", i, rsp_valid);
      end
    end
    do_txn(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1, got, lat);
    checks++;
    if (got.sum !== 32'h2345_6789 || lat !== NW + 1) begin
      errors++;
      $display("FAIL reset_recover: sum=%h lat=%0d, required sum=23456789 lat=%0d", got.sum, lat, NW + 1);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic         op, cin;
    res_t         got, exp;
    int           lat;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom;
      if (i % 5 == 0) b = a;
      op = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
      exp = model(a, b, op, cin);
      do_txn(a, b, op, cin, int'($urandom_range(0, 3)), got, lat);
      checks++;
      if (got !== exp || lat !== NW + 1) begin
        errors++;
        $display("FAIL random_%0d: sum=%h cout=%b ovf=%b lat=%0d, required sum=%h cout=%b ovf=%b lat=%0d",
                 i, got.sum, got.cout, got.ovf, lat, exp.sum, exp.cout, exp.ovf, NW + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t exp_q[$];
    res_t exp;
    int   acc_cyc[4];
    int   n_acc = 0;
    bit   refresh = 0;
    rsp_ready = 1'b1;
    req_a = $urandom; req_b = $urandom; req_op = 1'($urandom_range(0, 1)); req_cin = 1'($urandom_range(0, 1));
    req_valid = 1'b1;
    for (int cyc = 0; cyc < 200 && n_acc < 4; cyc++) begin
      refresh = 0;
      if (req_ready) begin
        exp_q.push_back(model(req_a, req_b, req_op, req_cin));
        acc_cyc[n_acc] = cyc;
        n_acc++;
        refresh = 1;
      end
      if (rsp_valid) begin
        checks++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if ({rsp_sum, rsp_cout, rsp_ovf} !== exp) begin
          errors++;
          $display("FAIL b2b_result: sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                   rsp_sum, rsp_cout, rsp_ovf, exp.sum, exp.cout, exp.ovf);
        end
        $display("txn b2b -> sum=%h cout=%0d ovf=%0d", rsp_sum, rsp_cout, rsp_ovf);
      end
      @(posedge clk); #1;
      if (refresh) begin
        req_a = $urandom; req_b = $urandom;
        req_op = 1'($urandom_range(0, 1)); req_cin = 1'($urandom_range(0, 1));
      end
    end
    req_valid = 1'b0;
    checks++;
    if (n_acc !== 4) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d accepts, required 4", n_acc);
    end
    for (int i = 1; i < n_acc; i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] !== NW + 2) begin
        errors++;
        $display("FAIL b2b_interval_%0d: got %0d, required %0d", i, acc_cyc[i] - acc_cyc[i-1], NW + 2);
      end
    end
    for (int i = 0; i < 20 && !rsp_valid; i++) begin
      @(posedge clk); #1;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    checks++;
    if (rsp_valid !== 1'b1 || {rsp_sum, rsp_cout, rsp_ovf} !== exp) begin
      errors++;
      $display("FAIL b2b_last: vld=%b sum=%h, required vld=1 sum=%h", rsp_valid, rsp_sum, exp.sum);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_nwords1();
    logic [7:0] ta [2] = '{8'h7F, 8'hFF};
    logic [7:0] tb [2] = '{8'h01, 8'h01};
    logic [9:0] texp[2] = '{{8'h80, 1'b0, 1'b1}, {8'h00, 1'b1, 1'b0}};
    int         lat;
    for (int t = 0; t < 2; t++) begin
      req_a1 = ta[t]; req_b1 = tb[t]; req_op1 = 1'b0; req_cin1 = 1'b0; req_valid1 = 1'b1;
      @(posedge clk); #1;
      req_valid1 = 1'b0;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
        if (rsp_valid1) begin
          lat = i;
          break;
        end
        @(posedge clk); #1;
      end
      checks++;
      if ({rsp_sum1, rsp_cout1, rsp_ovf1} !== texp[t] || lat !== 2) begin
        errors++;
        $display("FAIL nw1_%0d: sum=%h cout=%b ovf=%b lat=%0d, required sum=%h cout=%b ovf=%b lat=2",
                 t, rsp_sum1, rsp_cout1, rsp_ovf1, lat, texp[t][9:2], texp[t][1], texp[t][0]);
      end
      $display("txn nw1 a=%h b=%h -> sum=%h cout=%0d ovf=%0d lat=%0d",
               ta[t], tb[t], rsp_sum1, rsp_cout1, rsp_ovf1, lat);
      rsp_ready1 = 1'b1;
      @(posedge clk); #1;
      rsp_ready1 = 1'b0;
    end
  endtask

  initial begin
    req_valid = 1'b0; req_op = 1'b0; req_cin = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    req_valid1 = 1'b0; req_op1 = 1'b0; req_cin1 = 1'b0; req_a1 = '0; req_b1 = '0; rsp_ready1 = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    test_nwords1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ripple_add_sequencer.md
# ripple_add_sequencer

Multi-precision add/subtract sequencer built around the 8-bit ripple-carry adder datapath. It accepts two NWORDS×8-bit operands over a valid/ready request channel and feeds them through a single ripple_carry_adder8 one byte per cycle, least significant byte first. It registers the inter-word carry and assembles the result. The result is returned on a valid/ready response channel with carry-out and signed-overflow flags.

## Interface
- NWORDS, 4, number of 8-bit words per operand; legal range 1..16; operand width W = 8*NWORDS
- clk  in  1  clock, all state rising-edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer idle, can accept
- req_op  in  1  0 = add (a+b), 1 = subtract (a−b)
- req_a  in  W  operand a
- req_b  in  W  operand b
- req_cin  in  1  carry-in for add, borrow-in for subtract
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_sum  out  W  result
- rsp_cout  out  1  final carry; for subtract, 1 = no borrow
- rsp_ovf  out  1  two's-complement overflow of the W-bit operation

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE
  - req_ready = 1.
  - On req_valid && req_ready, latch a_q = req_a and b_q = req_op ? ~req_b : req_b.
  - Set carry_q = req_op ? ~req_cin : req_cin and idx = 0, then go to RUN.
- RUN
  - Adder inputs: a_q[idx], b_q[idx], carry_q.
  - Each cycle, write the adder sum into sum_q[idx] and load carry_q with the adder cout.
  - If idx == NWORDS−1, go to DONE; otherwise increment idx.
- DONE
  - rsp_valid = 1; rsp_sum = sum_q; rsp_cout = carry_q.
  - rsp_ovf = (a_q[W−1] == b_q[W−1]) && (sum_q[W−1] != a_q[W−1]), computed on the inverted b for subtract.
  - On rsp_ready, go to IDLE.
- req_ready is 0 in RUN and DONE, so there is never more than one transaction in flight.
- rsp_* outputs are held stable from rsp_valid rising until the handshake completes. They remain at their last values in IDLE.
- idx width is clog2(NWORDS), minimum 1 bit. For NWORDS = 1, RUN lasts exactly one cycle.
- Reset mid-operation:
  - Aborts the transaction with no response.
  - Clears state to IDLE, and clears idx, carry_q, a_q, b_q and sum_q to 0.
- Reset values: req_ready = 1 (IDLE decode), rsp_valid = 0, rsp_sum = 0, rsp_cout = 0, rsp_ovf = 0.
- Requesters must not assert req_valid while rst_n is low.

## Timing
- Accept edge at T0. RUN occupies the edges T1..T_NWORDS. rsp_valid is high from cycle T_NWORDS+1 (NWORDS+1 cycles after accept).
- If rsp_ready is high on the first DONE cycle, req_ready returns the cycle after. Minimum initiation interval is NWORDS+2 cycles.
- The adder path is combinational within one cycle. Its inputs are registers only, and the word mux is indexed by idx.
- All outputs decode directly from registers, with no input-to-output combinational path:
  - req_ready = (state==IDLE)
  - rsp_valid = (state==DONE)

## Structure
- Shared package ripple_add_pkg holds:
  - WORD_W = 8
  - state enum {IDLE, RUN, DONE}
  - op constants OP_ADD = 1'b0, OP_SUB = 1'b1
- Sub-module: one instance of the existing ripple_carry_adder8 (ports a, b, cin, cout, sum). There are no other sub-modules.
- The word mux, sum write-back, FSM and flag logic live in the top module.

## Test plan
- NWORDS=4, add 0x000000FF + 0x00000001, cin 0 → sum 0x00000100, cout 0, ovf 0. rsp_valid rises 5 cycles after the accept edge.
- Add 0xFFFFFFFF + 0x00000000, cin 1 → sum 0x00000000, cout 1, ovf 0 (carry ripples through all 4 words).
- Sub 0x80000000 − 0x00000001, cin 0 → sum 0x7FFFFFFF, cout 1, ovf 1. Sub 0x00000005 − 0x00000007 → sum 0xFFFFFFFE, cout 0 (borrow), ovf 0.
- Hold rsp_ready low for 6 cycles in DONE with req_valid high → rsp_sum and the flags stay stable, req_ready stays 0, and no second accept occurs. Raise rsp_ready → IDLE, then the next accept occurs one cycle later.
- Assert rst_n low while idx = 2 → rsp_valid 0, rsp_sum 0, req_ready 1 during reset. After release, add 0x12345678 + 0x11111111 → 0x23456789.
- NWORDS=1 build: add 0x7F + 0x01 → sum 0x80, cout 0, ovf 1. rsp_valid rises 2 cycles after accept.
